// File: rtl/rx_recv_pkg.sv
// Frame constants and parser state encoding for the old-protocol (Metis) UDP path.
// The TX send path uses these frame constants as well.
package rx_recv_pkg;

    localparam logic [7:0] FRAME_SYNC0 = 8'hEF;
    localparam logic [7:0] FRAME_SYNC1 = 8'hFE;
    localparam logic [7:0] FRAME_DATA  = 8'h01;
    localparam logic [7:0] FRAME_DISC  = 8'h02;
    localparam logic [7:0] FRAME_CMD   = 8'h04;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_TYPE,
        ST_EP,
        ST_SEQ,
        ST_DATA,
        ST_CMD,
        ST_DISC,
        ST_DROP
    } rx_state_e;

endpackage

// File: rtl/rx_recv.sv
// Metis UDP receive parser: EF FE data/discovery/start-stop frames, EP2 bytes to the Rx FIFO.
// Latency 1 cycle byte-in to FIFO write; no backpressure upstream, bytes seen while Rx_fifo_full are dropped.
module rx_recv
    import rx_recv_pkg::*;
#(
    parameter int         DATA_LEN = 1024,
    parameter logic [7:0] EP_OUT   = 8'h02,
    parameter int         ERRW     = 8
) (
    input  logic            rx_clock,
    input  logic            Rx_reset,
    input  logic            udp_rx_active,
    input  logic [7:0]      udp_rx_data,
    input  logic            Rx_fifo_full,
    input  logic            discovery_ack,
    output logic            Rx_fifo_wrreq,
    output logic [7:0]      Rx_fifo_wdata,
    output logic            run,
    output logic            wide_spectrum,
    output logic            discovery,
    output logic            seq_err,
    output logic [ERRW-1:0] seq_err_count,
    output logic            fifo_overflow
);

    localparam logic [10:0] LAST_B = 11'(DATA_LEN + 7);

    rx_state_e       state_q, state_d;
    logic [10:0]     b_q, b_d;
    logic [23:0]     seq_q, seq_d;
    logic [31:0]     exp_q, exp_d;
    logic            exp_vld_q, exp_vld_d;
    logic            skip_q, skip_d;
    logic            wrreq_q, wrreq_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            run_q, run_d;
    logic            ws_q, ws_d;
    logic            disc_q, disc_d;
    logic            seq_err_q, seq_err_d;
    logic [ERRW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     rx_seq;
    logic            disc_set;

    always_comb begin
        state_d   = state_q;
        b_d       = udp_rx_active ? b_q + 11'd1 : 11'd0;
        seq_d     = seq_q;
        exp_d     = exp_q;
        exp_vld_d = exp_vld_q;
        skip_d    = skip_q & udp_rx_active;
        wrreq_d   = 1'b0;
        wdata_d   = wdata_q;
        run_d     = run_q;
        ws_d      = ws_q;
        seq_err_d = 1'b0;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        disc_set  = 1'b0;
        rx_seq    = {seq_q, udp_rx_data};

        if (!udp_rx_active) begin
            disc_set = (state_q == ST_DISC);
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                // skip_q marks a packet already in flight when reset released
                ST_IDLE: state_d = (!skip_q && udp_rx_data == FRAME_SYNC0) ? ST_HDR : ST_DROP;
                ST_HDR:  state_d = (udp_rx_data == FRAME_SYNC1) ? ST_TYPE : ST_DROP;
                ST_TYPE: begin
                    case (udp_rx_data)
                        FRAME_DATA: state_d = ST_EP;
                        FRAME_DISC: state_d = ST_DISC;
                        FRAME_CMD:  state_d = ST_CMD;
                        default:    state_d = ST_DROP;
                    endcase
                end
                ST_EP:   state_d = (udp_rx_data == EP_OUT) ? ST_SEQ : ST_DROP;
                ST_SEQ: begin
                    seq_d = rx_seq[23:0];
                    if (b_q == 11'd7) begin
                        if (exp_vld_q && rx_seq != exp_q) begin
                            seq_err_d = 1'b1;
                            if (cnt_q != {ERRW{1'b1}})
                                cnt_d = cnt_q + 1'b1;
                        end
                        exp_d     = rx_seq + 32'd1;
                        exp_vld_d = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wdata_d = udp_rx_data;
                    if (Rx_fifo_full)
                        ovf_d = 1'b1;
                    else
                        wrreq_d = 1'b1;
                    if (b_q == LAST_B)
                        state_d = ST_DROP;
                end
                ST_CMD: begin
                    run_d = udp_rx_data[0];
                    ws_d  = udp_rx_data[1];
                    // a fresh start has no sequence history to compare against
                    if (udp_rx_data[0] && !run_q)
                        exp_vld_d = 1'b0;
                    state_d = ST_DROP;
                end
                default: state_d = state_q;
            endcase
        end

        disc_d = disc_set | (disc_q & ~discovery_ack);
    end

    always_ff @(posedge rx_clock) begin
        if (Rx_reset) begin
            state_q   <= ST_IDLE;
            b_q       <= 11'd0;
            seq_q     <= 24'd0;
            exp_q     <= 32'd0;
            exp_vld_q <= 1'b0;
            skip_q    <= udp_rx_active;
            wrreq_q   <= 1'b0;
            wdata_q   <= 8'd0;
            run_q     <= 1'b0;
            ws_q      <= 1'b0;
            disc_q    <= 1'b0;
            seq_err_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            seq_q     <= seq_d;
            exp_q     <= exp_d;
            exp_vld_q <= exp_vld_d;
            skip_q    <= skip_d;
            wrreq_q   <= wrreq_d;
            wdata_q   <= wdata_d;
            run_q     <= run_d;
            ws_q      <= ws_d;
            disc_q    <= disc_d;
            seq_err_q <= seq_err_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Rx_fifo_wrreq = wrreq_q;
    assign Rx_fifo_wdata = wdata_q;
    assign run           = run_q;
    assign wide_spectrum = ws_q;
    assign discovery     = disc_q;
    assign seq_err       = seq_err_q;
    assign seq_err_count = cnt_q;
    assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_rx_recv.sv
// Scoreboard bench for rx_recv: expected FIFO writes queued as bytes are driven, popped on each wrreq.
module tb_rx_recv;

    localparam int DATA_LEN = 1024;
    localparam int ERRW     = 8;

    logic            clk = 1'b0;
    logic            Rx_reset = 1'b1;
    logic            udp_rx_active = 1'b0;
    logic [7:0]      udp_rx_data = 8'd0;
    logic            Rx_fifo_full = 1'b0;
    logic            discovery_ack = 1'b0;
    logic            Rx_fifo_wrreq;
    logic [7:0]      Rx_fifo_wdata;
    logic            run;
    logic            wide_spectrum;
    logic            discovery;
    logic            seq_err;
    logic [ERRW-1:0] seq_err_count;
    logic            fifo_overflow;

    rx_recv #(.DATA_LEN(DATA_LEN), .EP_OUT(8'h02), .ERRW(ERRW)) dut (
        .rx_clock      (clk),
        .Rx_reset      (Rx_reset),
        .udp_rx_active (udp_rx_active),
        .udp_rx_data   (udp_rx_data),
        .Rx_fifo_full  (Rx_fifo_full),
        .discovery_ack (discovery_ack),
        .Rx_fifo_wrreq (Rx_fifo_wrreq),
        .Rx_fifo_wdata (Rx_fifo_wdata),
        .run           (run),
        .wide_spectrum (wide_spectrum),
        .discovery     (discovery),
        .seq_err       (seq_err),
        .seq_err_count (seq_err_count),
        .fifo_overflow (fifo_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int unsigned c;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  pkt[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every FIFO write must match the oldest expected byte, one cycle after it was driven
    always @(negedge clk) begin
        if (seq_err === 1'b1) err_pulses++;
        if (Rx_fifo_wrreq === 1'b1) begin
            exp_t e;
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got wdata=%h with no write expected (cycle %0d)", Rx_fifo_wdata, cyc);
            end else begin
                e = sb.pop_front();
                if (Rx_fifo_wdata !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL wdata got %h at cycle %0d, expected %h at cycle %0d", Rx_fifo_wdata, cyc, e.d, e.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        udp_rx_active = 1'b1;
        udp_rx_data   = v;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        udp_rx_active = 1'b0;
        udp_rx_data   = 8'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_data(input logic [31:0] seq, input logic [7:0] ep, input int len);
        pkt.delete();
        pkt.push_back(8'hEF); pkt.push_back(8'hFE); pkt.push_back(8'h01); pkt.push_back(ep);
        pkt.push_back(seq[31:24]); pkt.push_back(seq[23:16]);
        pkt.push_back(seq[15:8]);  pkt.push_back(seq[7:0]);
        for (int k = 0; pkt.size() < len; k++) pkt.push_back(8'(k));
    endtask

    task automatic drive_pkt(input bit is_data, input int full_lo, input int full_hi,
                             input int rst_at, input bit ack_end);
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clk); #1;
            udp_rx_active = 1'b1;
            udp_rx_data   = pkt[i];
            Rx_fifo_full  = (i >= full_lo && i <= full_hi);
            Rx_reset      = (i == rst_at);
            if (is_data && i >= 8 && i < DATA_LEN + 8 && !Rx_fifo_full && (rst_at < 0 || i < rst_at))
                sb.push_back('{d: pkt[i], c: cyc + 1});
        end
        @(posedge clk); #1;
        udp_rx_active = 1'b0;
        udp_rx_data   = 8'd0;
        Rx_fifo_full  = 1'b0;
        Rx_reset      = 1'b0;
        discovery_ack = ack_end;
        @(posedge clk); #1;
        discovery_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 Rx_reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({Rx_fifo_wrreq, run, wide_spectrum, discovery, seq_err, fifo_overflow} !== 6'b0 ||
            seq_err_count !== '0) begin
            errors++;
            $display("FAIL reset_values got wr=%b run=%b ws=%b disc=%b serr=%b ovf=%b cnt=%0d, expected all 0",
                     Rx_fifo_wrreq, run, wide_spectrum, discovery, seq_err, fifo_overflow, seq_err_count);
        end
    endtask

    task automatic test_start_stop;
        send_byte(8'hEF); send_byte(8'hFE); send_byte(8'h04); send_byte(8'h03);
        @(negedge clk);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL run_early got %b, expected 0 before b3 is taken", run);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (run !== 1'b1 || wide_spectrum !== 1'b1) begin
            errors++;
            $display("FAIL start got run=%b ws=%b, expected 1 1", run, wide_spectrum);
        end
        idle(3);
        send_byte(8'hEF); send_byte(8'hFE); send_byte(8'h04); send_byte(8'h00);
        idle(3);
        checks++;
        if (run !== 1'b0 || wide_spectrum !== 1'b0) begin
            errors++;
            $display("FAIL stop got run=%b ws=%b, expected 0 0", run, wide_spectrum);
        end
    endtask

    task automatic test_data_seq;
        int w0 = wr_cnt;
        int p0 = err_pulses;
        build_data(32'd5, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt - w0 != DATA_LEN || err_pulses != p0) begin
            errors++;
            $display("FAIL data_seq5 got writes=%0d pulses=%0d, expected %0d 0", wr_cnt - w0, err_pulses - p0, DATA_LEN);
        end
        w0 = wr_cnt;
        build_data(32'd7, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        checks++;
        if (err_pulses - p0 != 1 || seq_err_count !== 8'd1 || wr_cnt - w0 != DATA_LEN) begin
            errors++;
            $display("FAIL seq_gap got pulses=%0d count=%0d writes=%0d, expected 1 1 %0d",
                     err_pulses - p0, seq_err_count, wr_cnt - w0, DATA_LEN);
        end
    endtask

    task automatic test_discovery;
        pkt.delete();
        pkt.push_back(8'hEF); pkt.push_back(8'hFE); pkt.push_back(8'h02);
        for (int k = 0; k < 60; k++) pkt.push_back(8'h00);
        drive_pkt(1'b0, -1, -1, -1, 1'b0);
        checks++;
        if (discovery !== 1'b1) begin
            errors++;
            $display("FAIL disc_set got %b, expected 1", discovery);
        end
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (discovery !== 1'b1) begin
            errors++;
            $display("FAIL disc_hold got %b, expected 1", discovery);
        end
        @(posedge clk); #1 discovery_ack = 1'b1;
        @(posedge clk); #1 discovery_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (discovery !== 1'b0) begin
            errors++;
            $display("FAIL disc_ack got %b, expected 0", discovery);
        end
        drive_pkt(1'b0, -1, -1, -1, 1'b1);
        checks++;
        if (discovery !== 1'b1) begin
            errors++;
            $display("FAIL disc_set_wins got %b, expected 1", discovery);
        end
        @(posedge clk); #1 discovery_ack = 1'b1;
        @(posedge clk); #1 discovery_ack = 1'b0;
    endtask

    task automatic test_overflow;
        int w0 = wr_cnt;
        build_data(32'd8, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, 18, 27, -1, 1'b0);
        checks++;
        if (wr_cnt - w0 != DATA_LEN - 10 || fifo_overflow !== 1'b1 || seq_err_count !== 8'd1) begin
            errors++;
            $display("FAIL overflow got writes=%0d ovf=%b cnt=%0d, expected %0d 1 1",
                     wr_cnt - w0, fifo_overflow, seq_err_count, DATA_LEN - 10);
        end
    endtask

    task automatic test_bad_frames;
        int w0 = wr_cnt;
        int p0 = err_pulses;
        build_data(32'd9, 8'h04, 40);
        drive_pkt(1'b0, -1, -1, -1, 1'b0);
        build_data(32'd9, 8'h02, 40);
        pkt[0] = 8'hEE;
        drive_pkt(1'b0, -1, -1, -1, 1'b0);
        build_data(32'd9, 8'h02, 40);
        pkt[2] = 8'h03;
        drive_pkt(1'b0, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt != w0 || err_pulses != p0 || run !== 1'b0 || wide_spectrum !== 1'b0 ||
            discovery !== 1'b0 || seq_err_count !== 8'd1 || fifo_overflow !== 1'b1) begin
            errors++;
            $display("FAIL bad_frames got writes=%0d pulses=%0d run=%b ws=%b disc=%b cnt=%0d ovf=%b, expected 0 0 0 0 0 1 1",
                     wr_cnt - w0, err_pulses - p0, run, wide_spectrum, discovery, seq_err_count, fifo_overflow);
        end
        w0 = wr_cnt;
        build_data(32'd9, 8'h02, 500);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt - w0 != 492 || err_pulses != p0) begin
            errors++;
            $display("FAIL truncated got writes=%0d pulses=%0d, expected 492 0", wr_cnt - w0, err_pulses - p0);
        end
        w0 = wr_cnt;
        build_data(32'd10, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt - w0 != DATA_LEN || err_pulses != p0 || seq_err_count !== 8'd1) begin
            errors++;
            $display("FAIL after_trunc got writes=%0d pulses=%0d cnt=%0d, expected %0d 0 1",
                     wr_cnt - w0, err_pulses - p0, seq_err_count, DATA_LEN);
        end
    endtask

    task automatic test_reset_mid_and_wrap;
        int w0;
        int p0;
        send_byte(8'hEF); send_byte(8'hFE); send_byte(8'h04); send_byte(8'h01);
        idle(3);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL run_before_reset got %b, expected 1", run);
        end
        w0 = wr_cnt;
        build_data(32'd11, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, 308, 1'b0);
        checks++;
        if (wr_cnt - w0 != 300 || run !== 1'b0 || wide_spectrum !== 1'b0 || discovery !== 1'b0 ||
            seq_err_count !== 8'd0 || fifo_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got writes=%0d run=%b ws=%b disc=%b cnt=%0d ovf=%b, expected 300 0 0 0 0 0",
                     wr_cnt - w0, run, wide_spectrum, discovery, seq_err_count, fifo_overflow);
        end
        w0 = wr_cnt;
        p0 = err_pulses;
        build_data(32'hFFFF_FFFF, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        build_data(32'h0000_0000, 8'h02, DATA_LEN + 8);
        drive_pkt(1'b1, -1, -1, -1, 1'b0);
        checks++;
        if (wr_cnt - w0 != 2 * DATA_LEN || err_pulses != p0 || seq_err_count !== 8'd0) begin
            errors++;
            $display("FAIL seq_wrap got writes=%0d pulses=%0d cnt=%0d, expected %0d 0 0",
                     wr_cnt - w0, err_pulses - p0, seq_err_count, 2 * DATA_LEN);
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_data_seq();
        test_discovery();
        test_overflow();
        test_bad_frames();
        test_reset_mid_and_wrap();
        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d expected writes outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
